// File: rtl/pref_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pref_pkg : shared address widths and types for the IP-stride prefetcher
// Rev 1.0
// ------------------------------------------------------------------
package pref_pkg;

    localparam int ADDR_SIZE       = 64;
    localparam int LOG2_BLOCK_SIZE = 6;
    localparam int LOG2_PAGE_SIZE  = 12;
    localparam int CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [CLA_SIZE-1:0]  cla_t;

    function automatic cla_t addr_to_cla(input addr_t addr);
        return addr[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
    endfunction

    function automatic addr_t cla_to_addr(input cla_t cla);
        return {cla, {LOG2_BLOCK_SIZE{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pref_multi_push_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// pref_multi_push_fifo : circular queue, up to 3 pushes + 1 pop per cycle,
// all entries and valid bits exposed for duplicate search.   Rev 1.0
// ------------------------------------------------------------------
module pref_multi_push_fifo
    import pref_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                push_cnt_i,
    input  cla_t [2:0]                push_data_i,
    input  logic                      pop_i,
    output cla_t                      head_o,
    output cla_t [DEPTH-1:0]          entries_o,
    output logic [DEPTH-1:0]          valid_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cla_t [DEPTH-1:0]  mem_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    // Push data arrives compacted: slot i of push_data_i goes to tail+i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) < push_cnt_i) begin
                    mem_q[tail_q + PTR_W'(i)] <= push_data_i[i];
                end
            end
            if (pop_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            tail_q  <= tail_q + PTR_W'(push_cnt_i);
            count_q <= count_q - CNT_W'(pop_i) + CNT_W'(push_cnt_i);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PTR_W-1:0] rel;
        assign rel        = PTR_W'(g) - head_q;
        assign valid_o[g] = ({1'b0, rel} < count_q);
    end

    assign head_o    = mem_q[head_q];
    assign entries_o = mem_q;
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/pref_issue_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// pref_issue_queue : dedups degree-3 prefetch candidates against queue and
// recently-issued filter, issues one per cycle over valid/ready.   Rev 1.0
// ------------------------------------------------------------------
module pref_issue_queue
    import pref_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int RIF_DEPTH   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  addr_t                         pref_addr1_i,
    input  logic                          pref_valid1_i,
    input  addr_t                         pref_addr2_i,
    input  logic                          pref_valid2_i,
    input  addr_t                         pref_addr3_i,
    input  logic                          pref_valid3_i,
    output logic                          req_valid_o,
    output addr_t                         req_addr_o,
    input  logic                          req_ready_i,
    output logic [$clog2(QUEUE_DEPTH):0]  occupancy_o,
    output logic [CNT_WIDTH-1:0]          drop_full_cnt_o,
    output logic [CNT_WIDTH-1:0]          drop_dup_cnt_o
);

    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RIF_PTR_W = $clog2(RIF_DEPTH);
    localparam int SUM_W     = CNT_WIDTH + 1;

    cla_t [2:0]               cand_line;
    logic [2:0]               cand_valid;

    cla_t                     head_line;
    cla_t [QUEUE_DEPTH-1:0]   q_entries;
    logic [QUEUE_DEPTH-1:0]   q_valid;
    logic [CNT_W-1:0]         q_count;

    logic                     fire;
    logic [CNT_W-1:0]         free_slots;
    logic [1:0]               n_acc;
    cla_t [2:0]               push_data;
    logic [2:0]               is_dup;
    logic [2:0]               is_acc;
    logic [2:0]               is_full;
    logic                     hit;

    cla_t [RIF_DEPTH-1:0]     rif_q;
    logic [RIF_DEPTH-1:0]     rif_valid_q;
    logic [RIF_PTR_W-1:0]     rif_wptr_q;

    logic [CNT_WIDTH-1:0]     drop_full_q;
    logic [CNT_WIDTH-1:0]     drop_full_d;
    logic [CNT_WIDTH-1:0]     drop_dup_q;
    logic [CNT_WIDTH-1:0]     drop_dup_d;
    logic [SUM_W-1:0]         full_sum;
    logic [SUM_W-1:0]         dup_sum;

    assign cand_line  = {addr_to_cla(pref_addr3_i), addr_to_cla(pref_addr2_i),
                         addr_to_cla(pref_addr1_i)};
    assign cand_valid = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

    pref_multi_push_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_cnt_i  (n_acc),
        .push_data_i (push_data),
        .pop_i       (fire),
        .head_o      (head_line),
        .entries_o   (q_entries),
        .valid_o     (q_valid),
        .count_o     (q_count)
    );

    // Outputs come straight from queue state, so they hold while stalled.
    assign req_valid_o = (q_count != '0);
    assign req_addr_o  = cla_to_addr(head_line);
    assign occupancy_o = q_count;
    assign fire        = req_valid_o & req_ready_i;
    assign free_slots  = CNT_W'(QUEUE_DEPTH) - q_count + CNT_W'(fire);

    always_comb begin
        is_dup    = '0;
        is_acc    = '0;
        is_full   = '0;
        n_acc     = '0;
        push_data = '0;
        hit       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hit = 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (q_valid[i] && (q_entries[i] == cand_line[k])) hit = 1'b1;
            end
            for (int r = 0; r < RIF_DEPTH; r++) begin
                if (rif_valid_q[r] && (rif_q[r] == cand_line[k])) hit = 1'b1;
            end
            // Earlier same-cycle candidates only count once they were kept or already deduped.
            for (int j = 0; j < k; j++) begin
                if ((is_acc[j] || is_dup[j]) && (cand_line[j] == cand_line[k])) hit = 1'b1;
            end
            if (cand_valid[k]) begin
                if (hit) begin
                    is_dup[k] = 1'b1;
                end else if (CNT_W'(n_acc) < free_slots) begin
                    is_acc[k]        = 1'b1;
                    push_data[n_acc] = cand_line[k];
                    n_acc            = n_acc + 2'd1;
                end else begin
                    is_full[k] = 1'b1;
                end
            end
        end
    end

    assign full_sum = {1'b0, drop_full_q} + SUM_W'($countones(is_full));
    assign dup_sum  = {1'b0, drop_dup_q}  + SUM_W'($countones(is_dup));

    always_comb begin
        drop_full_d = full_sum[CNT_WIDTH] ? '1 : full_sum[CNT_WIDTH-1:0];
        drop_dup_d  = dup_sum[CNT_WIDTH]  ? '1 : dup_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rif_q       <= '0;
            rif_valid_q <= '0;
            rif_wptr_q  <= '0;
            drop_full_q <= '0;
            drop_dup_q  <= '0;
        end else begin
            if (fire) begin
                rif_q[rif_wptr_q]       <= head_line;
                rif_valid_q[rif_wptr_q] <= 1'b1;
                rif_wptr_q <= (rif_wptr_q == RIF_PTR_W'(RIF_DEPTH - 1)) ? '0
                                                                       : rif_wptr_q + RIF_PTR_W'(1);
            end
            drop_full_q <= drop_full_d;
            drop_dup_q  <= drop_dup_d;
        end
    end

    assign drop_full_cnt_o = drop_full_q;
    assign drop_dup_cnt_o  = drop_dup_q;

endmodule
`default_nettype wire

// File: tb/tb_pref_issue_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pref_issue_queue : directed vector table plus multi-cycle sequences.
// Rev 1.0
// ------------------------------------------------------------------
module tb_pref_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a1 = '0, a2 = '0, a3 = '0;
    logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic        ready = 1'b0;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [3:0]  occ;
    logic [15:0] dfull;
    logic [15:0] ddup;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pref_issue_queue #(
        .QUEUE_DEPTH (8),
        .RIF_DEPTH   (16),
        .CNT_WIDTH   (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pref_addr1_i    (a1),
        .pref_valid1_i   (v1),
        .pref_addr2_i    (a2),
        .pref_valid2_i   (v2),
        .pref_addr3_i    (a3),
        .pref_valid3_i   (v3),
        .req_valid_o     (req_valid),
        .req_addr_o      (req_addr),
        .req_ready_i     (ready),
        .occupancy_o     (occ),
        .drop_full_cnt_o (dfull),
        .drop_dup_cnt_o  (ddup)
    );

    typedef struct {
        logic        ready;
        logic        v1, v2, v3;
        logic [63:0] a1, a2, a3;
        logic        ev;
        logic [63:0] ea;
        logic [3:0]  occ;
        logic [15:0] df, dd;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c1, input logic c2, input logic c3,
                         input logic [63:0] x1, input logic [63:0] x2, input logic [63:0] x3);
        ready = r; v1 = c1; v2 = c2; v3 = c3; a1 = x1; a2 = x2; a3 = x3;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic ev, input logic [63:0] ea,
                             input logic [3:0] eocc, input logic [15:0] edf, input logic [15:0] edd);
        chk({nm, ".valid"}, 64'(req_valid), 64'(ev));
        if (ev) chk({nm, ".addr"}, req_addr, ea);
        chk({nm, ".occ"}, 64'(occ), 64'(eocc));
        chk({nm, ".drop_full"}, 64'(dfull), 64'(edf));
        chk({nm, ".drop_dup"}, 64'(ddup), 64'(edd));
    endtask

    logic [63:0] drain_exp [8] = '{64'h4040, 64'h4080, 64'h40C0, 64'h4100,
                                   64'h4140, 64'h4180, 64'hFFFF_FFFF_FFFF_FFC0, 64'h4200};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ready, v1 v2 v3, a1 a2 a3, exp_valid, exp_addr, exp_occ, exp_drop_full, exp_drop_dup
        tbl[0]  = '{1'b1, 1'b1,1'b0,1'b0, 64'h1000, 64'h0, 64'h0, 1'b1, 64'h1000, 4'd1, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0, 4'd0, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1,1'b1,1'b1, 64'h1040, 64'h1040, 64'h107F, 1'b1, 64'h1040, 4'd1, 16'd0, 16'd2};
        tbl[3]  = '{1'b0, 1'b1,1'b0,1'b0, 64'h1000, 64'h0, 64'h0, 1'b1, 64'h1040, 4'd1, 16'd0, 16'd3};
        tbl[4]  = '{1'b0, 1'b1,1'b1,1'b0, 64'h1040, 64'h1080, 64'h0, 1'b1, 64'h1040, 4'd2, 16'd0, 16'd4};
        tbl[5]  = '{1'b1, 1'b1,1'b0,1'b0, 64'h1040, 64'h0, 64'h0, 1'b1, 64'h1080, 4'd1, 16'd0, 16'd5};
        tbl[6]  = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0, 4'd0, 16'd0, 16'd5};
        tbl[7]  = '{1'b0, 1'b1,1'b1,1'b1, 64'h3000, 64'h3040, 64'h3080, 1'b1, 64'h3000, 4'd3, 16'd0, 16'd5};
        tbl[8]  = '{1'b0, 1'b1,1'b1,1'b1, 64'h30C0, 64'h3100, 64'h3140, 1'b1, 64'h3000, 4'd6, 16'd0, 16'd5};
        tbl[9]  = '{1'b0, 1'b1,1'b1,1'b1, 64'h3180, 64'h31C0, 64'h3200, 1'b1, 64'h3000, 4'd8, 16'd1, 16'd5};
        tbl[10] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h3040, 4'd7, 16'd1, 16'd5};
        tbl[11] = '{1'b0, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h3040, 4'd7, 16'd1, 16'd5};
        tbl[12] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h3080, 4'd6, 16'd1, 16'd5};
        tbl[13] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h30C0, 4'd5, 16'd1, 16'd5};
        tbl[14] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h3100, 4'd4, 16'd1, 16'd5};
        tbl[15] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h3140, 4'd3, 16'd1, 16'd5};
        tbl[16] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h3180, 4'd2, 16'd1, 16'd5};
        tbl[17] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h31C0, 4'd1, 16'd1, 16'd5};
        tbl[18] = '{1'b1, 1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0, 4'd0, 16'd1, 16'd5};
        tbl[19] = '{1'b0, 1'b0,1'b1,1'b1, 64'hDEAD_0000, 64'h4005, 64'h4040, 1'b1, 64'h4000, 4'd2, 16'd1, 16'd5};
        tbl[20] = '{1'b0, 1'b1,1'b0,1'b1, 64'h4080, 64'h4080, 64'h40C0, 1'b1, 64'h4000, 4'd4, 16'd1, 16'd5};
        tbl[21] = '{1'b0, 1'b1,1'b1,1'b1, 64'h4100, 64'h4140, 64'h4180, 1'b1, 64'h4000, 4'd7, 16'd1, 16'd5};
        tbl[22] = '{1'b0, 1'b1,1'b0,1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 64'h0, 1'b1, 64'h4000, 4'd8, 16'd1, 16'd5};
        tbl[23] = '{1'b1, 1'b1,1'b1,1'b1, 64'h4200, 64'h4240, 64'h4280, 1'b1, 64'h4040, 4'd8, 16'd3, 16'd5};
        tbl[24] = '{1'b0, 1'b1,1'b1,1'b1, 64'h4040, 64'h42C0, 64'h4300, 1'b1, 64'h4040, 4'd8, 16'd5, 16'd6};

        // Reset held two cycles with candidates offered.
        rst_n = 1'b0;
        ready = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
        a1 = 64'h7000; a2 = 64'h7040; a3 = 64'h7080;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 64'h0, 4'd0, 16'd0, 16'd0);
        chk("reset.addr", req_addr, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].ready, tbl[i].v1, tbl[i].v2, tbl[i].v3, tbl[i].a1, tbl[i].a2, tbl[i].a3);
            chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].occ, tbl[i].df, tbl[i].dd);
        end

        // Drain the wrapped, full queue in FIFO order.
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d.addr", k), req_addr, drain_exp[k]);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        end
        chk_state("drained", 1'b0, 64'h0, 4'd0, 16'd5, 16'd6);

        // Recently-issued filter: 0x2000 blocked until 16 newer lines have issued.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0);
        chk_state("rif.push", 1'b1, 64'h2000, 4'd1, 16'd5, 16'd6);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        chk_state("rif.issue", 1'b0, 64'h0, 4'd0, 16'd5, 16'd6);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0);
        chk_state("rif.dup1", 1'b0, 64'h0, 4'd0, 16'd5, 16'd7);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h5000 + 64'(i) * 64'h40, 64'h0, 64'h0);
            chk_state($sformatf("rif.stream%0d", i), 1'b1, 64'h5000 + 64'(i) * 64'h40, 4'd1, 16'd5, 16'd7);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0);
        chk_state("rif.dup15", 1'b0, 64'h0, 4'd0, 16'd5, 16'd8);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h5400, 64'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0);
        chk_state("rif.evicted", 1'b1, 64'h2000, 4'd1, 16'd5, 16'd8);

        // Reset with a request pending clears queue, filter and counters.
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0);
        chk_state("midreset", 1'b0, 64'h0, 4'd0, 16'd0, 16'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0);
        chk_state("postreset", 1'b1, 64'h2000, 4'd1, 16'd0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
